// File: rtl/key_scan_entry.sv
// 4x4 hex keypad scanner/debouncer feeding a 32-bit, 8-digit entry register.
// Optional macro BACKSPACE_EN: key 0xE removes the newest digit instead of entering it.
module key_scan_entry #(
  parameter int SCAN_DIV     = 20000,
  parameter int DEBOUNCE_CNT = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clr,
  output logic [31:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [3:0]  digit_cnt
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [3:0]      rs_meta_r, rs_r;
  logic [SW-1:0]   scan_cnt_r, scan_cnt_nxt_s;
  logic [DW-1:0]   db_cnt_r, db_cnt_nxt_s;
  logic [1:0]      col_idx_r, col_idx_nxt_s;
  logic [3:0]      cap_row_r, cap_row_nxt_s;
  logic            accept_s;
  logic [3:0]      code_s;
  logic            is_bksp_s;
  logic [31:0]     data_nxt_s;
  logic [3:0]      cnt_nxt_s;

  // Lowest active (low) row wins when several rows are pulled down.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  assign code_s = {row_index(cap_row_r), col_idx_r};

`ifdef BACKSPACE_EN
  assign is_bksp_s = (code_s == 4'hE);
`else
  assign is_bksp_s = 1'b0;
`endif

  // Scan/debounce FSM next-state logic.
  always_comb begin
    state_nxt_s    = state_r;
    scan_cnt_nxt_s = '0;
    db_cnt_nxt_s   = db_cnt_r;
    col_idx_nxt_s  = col_idx_r;
    cap_row_nxt_s  = cap_row_r;
    accept_s       = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (scan_cnt_r == SCAN_LAST) begin
          if (rs_r == 4'hF) begin
            col_idx_nxt_s = col_idx_r + 2'd1;
          end else begin
            cap_row_nxt_s = rs_r;
            db_cnt_nxt_s  = '0;
            state_nxt_s   = ST_PRESS_DB;
          end
        end else begin
          scan_cnt_nxt_s = scan_cnt_r + SW'(1);
        end
      end
      ST_PRESS_DB: begin
        if (rs_r == cap_row_r) begin
          if (db_cnt_r == DB_LAST) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            db_cnt_nxt_s = db_cnt_r + DW'(1);
          end
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_HOLD: begin
        if (rs_r == 4'hF) begin
          db_cnt_nxt_s = '0;
          state_nxt_s  = ST_REL_DB;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_REL_DB: begin
        if (rs_r == 4'hF) begin
          if (db_cnt_r == DB_LAST) begin
            state_nxt_s = ST_SCAN;
          end else begin
            db_cnt_nxt_s = db_cnt_r + DW'(1);
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_SCAN;
      end
    endcase
  end

  // Entry register update; clear takes priority over an accepted key.
  always_comb begin
    data_nxt_s = data;
    cnt_nxt_s  = digit_cnt;
    if (clr) begin
      data_nxt_s = 32'h0;
      cnt_nxt_s  = 4'd0;
    end else if (accept_s && is_bksp_s) begin
      data_nxt_s = {4'h0, data[31:4]};
      cnt_nxt_s  = (digit_cnt == 4'd0) ? 4'd0 : digit_cnt - 4'd1;
    end else if (accept_s) begin
      data_nxt_s = {data[27:0], code_s};
      cnt_nxt_s  = (digit_cnt >= 4'd8) ? 4'd8 : digit_cnt + 4'd1;
    end else begin
      data_nxt_s = data;
      cnt_nxt_s  = digit_cnt;
    end
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta_r  <= 4'hF;
      rs_r       <= 4'hF;
      state_r    <= ST_SCAN;
      scan_cnt_r <= '0;
      db_cnt_r   <= '0;
      col_idx_r  <= 2'd0;
      cap_row_r  <= 4'hF;
      col_out    <= 4'b1110;
      data       <= 32'h0;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      digit_cnt  <= 4'd0;
    end else begin
      rs_meta_r  <= row_in;
      rs_r       <= rs_meta_r;
      state_r    <= state_nxt_s;
      scan_cnt_r <= scan_cnt_nxt_s;
      db_cnt_r   <= db_cnt_nxt_s;
      col_idx_r  <= col_idx_nxt_s;
      cap_row_r  <= cap_row_nxt_s;
      col_out    <= ~(4'b0001 << col_idx_nxt_s);
      data       <= data_nxt_s;
      key_code   <= accept_s ? code_s : key_code;
      key_valid  <= accept_s;
      digit_cnt  <= cnt_nxt_s;
    end
  end

endmodule
